// File: rtl/tof_i2c_pkg.sv
// Shared types and constants for the ToF I2C target and initiator FSMs.
package tof_i2c_pkg;

    localparam logic [6:0]  TOF_DEV_ADDR = 7'h29;
    localparam logic        I2C_RW_WRITE = 1'b0;
    localparam logic        I2C_RW_READ  = 1'b1;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BITCNT_W     = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_IDX_HI,
        ST_IDX_HI_ACK,
        ST_IDX_LO,
        ST_IDX_LO_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchronizers plus registered SCL edge and START/STOP condition pulses.
module i2c_bus_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_start,
    output logic bus_stop,
    output logic sda_smp
);

    localparam int unsigned VLD_W = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [VLD_W-1:0]       vld_q, vld_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_rise_q, scl_rise_d;
    logic                   scl_fall_q, scl_fall_d;
    logic                   start_q, start_d;
    logic                   stop_q, stop_d;
    logic                   sda_q, sda_d;
    logic                   scl_s, sda_s, armed;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    // Suppress events until the pipeline holds real bus samples after reset.
    assign armed = vld_q[VLD_W-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        vld_d      = {vld_q[VLD_W-2:0], 1'b1};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        sda_d      = sda_s;
        scl_rise_d = armed &  scl_s & ~scl_prev_q;
        scl_fall_d = armed & ~scl_s &  scl_prev_q;
        start_d    = armed &  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
        stop_d     = armed &  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            vld_q      <= '0;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            sda_q      <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            vld_q      <= vld_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            sda_q      <= sda_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign bus_start = start_q;
    assign bus_stop  = stop_q;
    assign sda_smp   = sda_q;

endmodule

// File: rtl/tof_i2c_target.sv
// I2C target modelling a ToF sensor register file: 16-bit index, auto-increment reads/writes.
module tof_i2c_target
    import tof_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = TOF_DEV_ADDR,
    parameter int unsigned AW          = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_stb,
    output logic [AW-1:0]     wr_idx,
    output logic [BYTE_W-1:0] wr_data,
    output logic              busy,
    input  logic [AW-1:0]     dbg_idx,
    output logic [BYTE_W-1:0] dbg_data
);

    localparam int unsigned DEPTH = 32'(1) << AW;

    logic scl_rise, scl_fall, bus_start, bus_stop, sda_smp;

    i2c_bus_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_cond (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .bus_start (bus_start),
        .bus_stop  (bus_stop),
        .sda_smp   (sda_smp)
    );

    state_e              state_q, state_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic [BYTE_W-1:0]   idx_hi_q, idx_hi_d;
    logic [AW-1:0]       index_q, index_d;
    logic                rw_q, rw_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                wr_stb_q, wr_stb_d;
    logic [AW-1:0]       wr_idx_q, wr_idx_d;
    logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
    logic [BYTE_W-1:0]   dbg_data_q, dbg_data_d;
    logic [BYTE_W-1:0]   mem_q [DEPTH];
    logic [BYTE_W-1:0]   mem_d [DEPTH];
    logic [BYTE_W-1:0]   byte_in, rd_byte;

    assign byte_in = {shreg_q[BYTE_W-2:0], sda_smp};
    assign rd_byte = mem_q[index_q];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        idx_hi_d   = idx_hi_q;
        index_d    = index_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_stb_d   = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        mem_d      = mem_q;
        // Peek reads the pre-write array so a same-cycle write shows up next cycle.
        dbg_data_d = mem_q[dbg_idx];

        if (bus_stop) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (bus_start) begin
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ADDR, ST_IDX_HI, ST_IDX_LO, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                        if (bit_cnt_q == BITCNT_W'(7)) begin
                            bit_cnt_d = '0;
                            case (state_q)
                                ST_ADDR: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = ST_ADDR_ACK;
                                        rw_d    = byte_in[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = ST_IGNORE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_IDX_HI: begin
                                    idx_hi_d = byte_in;
                                    state_d  = ST_IDX_HI_ACK;
                                end
                                ST_IDX_LO: begin
                                    index_d = AW'({idx_hi_q, byte_in});
                                    state_d = ST_IDX_LO_ACK;
                                end
                                default: begin
                                    wr_stb_d         = 1'b1;
                                    wr_idx_d         = index_q;
                                    wr_data_d        = byte_in;
                                    mem_d[index_q]   = byte_in;
                                    index_d          = index_q + AW'(1);
                                    state_d          = ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First SCL fall starts driving the ACK, the next one ends it.
                ST_ADDR_ACK, ST_IDX_HI_ACK, ST_IDX_LO_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            case (state_q)
                                ST_ADDR_ACK: begin
                                    if (rw_q == I2C_RW_READ) begin
                                        state_d  = ST_RDATA;
                                        shreg_d  = rd_byte;
                                        sda_oe_d = ~rd_byte[BYTE_W-1];
                                    end else begin
                                        state_d = ST_IDX_HI;
                                    end
                                end
                                ST_IDX_HI_ACK: state_d = ST_IDX_LO;
                                default:       state_d = ST_WDATA;
                            endcase
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BITCNT_W'(8)) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            shreg_d  = BYTE_W'(shreg_q << 1);
                            sda_oe_d = ~shreg_d[BYTE_W-1];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_smp) begin
                            state_d = ST_IGNORE;
                        end else begin
                            index_d = index_q + AW'(1);
                        end
                    end else if (scl_fall) begin
                        state_d   = ST_RDATA;
                        bit_cnt_d = '0;
                        shreg_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[BYTE_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            idx_hi_q   <= '0;
            index_q    <= '0;
            rw_q       <= I2C_RW_WRITE;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            dbg_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            idx_hi_q   <= idx_hi_d;
            index_q    <= index_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_stb_q   <= wr_stb_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            dbg_data_q <= dbg_data_d;
            mem_q      <= mem_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign wr_stb   = wr_stb_q;
    assign wr_idx   = wr_idx_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_tof_i2c_target.sv
// Bench for tof_i2c_target: bit-banged I2C initiator plus a flat register-array reference model.
module tb_tof_i2c_target;
    import tof_i2c_pkg::*;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned Q     = 5;
    localparam logic [6:0]  DEV   = 7'h29;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scl_i, sda_m, sda_i;
    logic          sda_oe, wr_stb, busy;
    logic [AW-1:0] wr_idx, dbg_idx;
    logic [7:0]    wr_data, dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed { logic [5:0] idx; logic [7:0] data; } wr_ev_t;
    wr_ev_t     wr_q[$];
    logic [7:0] ref_mem [DEPTH];
    logic       oe_prev = 1'b0;

    assign sda_i = sda_m & ~sda_oe;

    tof_i2c_target #(.DEV_ADDR(DEV), .AW(AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_stb === 1'b1) wr_q.push_back({wr_idx, wr_data});
        if (rst_n === 1'b1 && sda_oe !== oe_prev) begin
            n_tests++;
            if (scl_i !== 1'b0) begin
                n_fail++;
                $display("FAIL oe_toggle_scl_high: scl=%0b required 0", scl_i);
            end
        end
        oe_prev = sda_oe;
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        if (scl_i == 1'b0) begin
            sda_m = 1'b1; q_wait();
            scl_i = 1'b1; q_wait();
        end
        sda_m = 1'b0; q_wait();
        scl_i = 1'b0; q_wait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q_wait();
        scl_i = 1'b1; q_wait();
        sda_m = 1'b1; q_wait(); q_wait();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    q_wait();
        scl_i = 1'b1; q_wait(); q_wait();
        scl_i = 1'b0; q_wait();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; q_wait();
        scl_i = 1'b1; q_wait();
        b = sda_i;    q_wait();
        scl_i = 1'b0; q_wait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic set_index(input logic [15:0] idx, output logic ok);
        logic a0, a1, a2;
        bus_start();
        write_byte({DEV, I2C_RW_WRITE}, a0);
        write_byte(idx[15:8], a1);
        write_byte(idx[7:0], a2);
        ok = a0 & a1 & a2;
    endtask

    task automatic peek(input logic [5:0] i, output logic [7:0] v);
        dbg_idx = i;
        repeat (2) @(negedge clk);
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0; scl_i = 1'b1; sda_m = 1'b1; dbg_idx = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %0b want 0", sda_oe); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++;
        if (wr_stb !== 1'b0 || wr_idx !== '0 || wr_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_wr: stb=%0b idx=%0h data=%0h want 0/0/0", wr_stb, wr_idx, wr_data);
        end
        n_tests++;
        if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL reset_dbg: got %0h want 00", dbg_data); end
        for (int k = 0; k < 3; k++) begin
            logic [5:0] p;
            p = 6'($urandom);
            peek(p, v);
            n_tests++;
            if (v !== ref_mem[p]) begin n_fail++; $display("FAIL reset_mem[%0d]: got %0h want %0h", p, v, ref_mem[p]); end
        end
    endtask

    task automatic test_write_basic();
        logic ok, a;
        logic [7:0] v;
        wr_ev_t exp_ev [2];
        wr_q.delete();
        set_index(16'h0010, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_basic_hdr_acks: got %0b want 1", ok); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_basic_busy: got %0b want 1", busy); end
        write_byte(8'hA5, a); ok = a;
        write_byte(8'h3C, a); ok &= a;
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_basic_data_acks: got %0b want 1", ok); end
        bus_stop();
        ref_mem[6'h10] = 8'hA5; ref_mem[6'h11] = 8'h3C;
        exp_ev[0] = {6'h10, 8'hA5}; exp_ev[1] = {6'h11, 8'h3C};
        n_tests++;
        if (wr_q.size() != 2) begin
            n_fail++; $display("FAIL wr_basic_count: got %0d want 2", wr_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (wr_q[k] !== exp_ev[k]) begin
                    n_fail++; $display("FAIL wr_basic_ev%0d: got %0h/%0h want %0h/%0h", k, wr_q[k].idx, wr_q[k].data, exp_ev[k].idx, exp_ev[k].data);
                end
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_basic_busy_stop: got %0b want 0", busy); end
        peek(6'h11, v);
        n_tests++;
        if (v !== ref_mem[6'h11]) begin n_fail++; $display("FAIL wr_basic_dbg: got %0h want %0h", v, ref_mem[6'h11]); end
    endtask

    task automatic test_random_read();
        logic ok, a;
        logic [7:0] b0, b1;
        wr_q.delete();
        set_index(16'h0010, ok);
        bus_start();
        write_byte({DEV, I2C_RW_READ}, a);
        n_tests++;
        if ((ok & a) !== 1'b1) begin n_fail++; $display("FAIL rd_acks: got %0b want 1", ok & a); end
        read_byte(b0, 1'b1);
        read_byte(b1, 1'b0);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %0b want 1", busy); end
        bus_stop();
        n_tests++;
        if (b0 !== ref_mem[6'h10] || b1 !== ref_mem[6'h11]) begin
            n_fail++; $display("FAIL rd_bytes: got %0h %0h want %0h %0h", b0, b1, ref_mem[6'h10], ref_mem[6'h11]);
        end
        n_tests++;
        if (busy !== 1'b0 || wr_q.size() != 0) begin
            n_fail++; $display("FAIL rd_after_stop: busy=%0b writes=%0d want 0/0", busy, wr_q.size());
        end
    endtask

    task automatic test_bad_addr();
        logic ok, a;
        logic [5:0] p;
        logic [7:0] d, v;
        wr_q.delete();
        bus_start();
        write_byte({7'h2A, I2C_RW_WRITE}, a);
        n_tests++;
        if (a !== 1'b0) begin n_fail++; $display("FAIL bad_addr_nack: ack=%0b want 0", a); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_addr_busy: got %0b want 0", busy); end
        write_byte(8'h00, a);
        write_byte(8'h05, a);
        write_byte(8'h55, a);
        bus_stop();
        n_tests++;
        if (wr_q.size() != 0) begin n_fail++; $display("FAIL bad_addr_writes: got %0d want 0", wr_q.size()); end
        p = 6'($urandom); d = 8'($urandom);
        set_index({10'($urandom), p}, ok);
        write_byte(d, a);
        bus_stop();
        ref_mem[p] = d;
        n_tests++;
        if ((ok & a) !== 1'b1 || wr_q.size() != 1) begin
            n_fail++; $display("FAIL bad_addr_recover: acks=%0b writes=%0d want 1/1", ok & a, wr_q.size());
        end
        peek(p, v);
        n_tests++;
        if (v !== ref_mem[p]) begin n_fail++; $display("FAIL bad_addr_recover_mem: got %0h want %0h", v, ref_mem[p]); end
    endtask

    task automatic test_wrap();
        logic ok, a;
        logic [7:0] v;
        wr_q.delete();
        set_index(16'h003F, ok);
        write_byte(8'h11, a);
        write_byte(8'h22, a);
        bus_stop();
        ref_mem[63] = 8'h11; ref_mem[0] = 8'h22;
        n_tests++;
        if (wr_q.size() != 2 || wr_q[0] !== wr_ev_t'({6'd63, 8'h11}) || wr_q[1] !== wr_ev_t'({6'd0, 8'h22})) begin
            n_fail++; $display("FAIL wrap_events: count=%0d want 2 events at 3f/00", wr_q.size());
        end
        peek(6'd63, v);
        n_tests++;
        if (v !== ref_mem[63]) begin n_fail++; $display("FAIL wrap_mem63: got %0h want %0h", v, ref_mem[63]); end
        peek(6'd0, v);
        n_tests++;
        if (v !== ref_mem[0]) begin n_fail++; $display("FAIL wrap_mem0: got %0h want %0h", v, ref_mem[0]); end
        wr_q.delete();
        set_index(16'h1234, ok);
        write_byte(8'h77, a);
        bus_stop();
        ref_mem[6'h34] = 8'h77;
        n_tests++;
        if (wr_q.size() != 1 || wr_q[0].idx !== 6'h34 || (ok & a) !== 1'b1) begin
            n_fail++; $display("FAIL trunc_idx: count=%0d acks=%0b want one write at 34", wr_q.size(), ok & a);
        end
    endtask

    task automatic test_random();
        logic ok, a;
        logic [15:0] widx, ridx;
        logic [7:0] d;
        logic [5:0] p;
        int n, m;
        wr_ev_t exp_q[$];
        for (int it = 0; it < 10; it++) begin
            wr_q.delete(); exp_q.delete();
            widx = 16'($urandom);
            n = $urandom_range(0, 3);
            set_index(widx, ok);
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                write_byte(d, a);
                ok &= a;
                p = 6'(widx + 16'(k));
                ref_mem[p] = d;
                exp_q.push_back({p, d});
            end
            bus_stop();
            n_tests++;
            if (ok !== 1'b1 || wr_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand_wr%0d: acks=%0b writes=%0d want 1/%0d", it, ok, wr_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    n_tests++;
                    if (wr_q[k] !== exp_q[k]) begin
                        n_fail++; $display("FAIL rand_wr%0d_ev%0d: got %0h/%0h want %0h/%0h", it, k, wr_q[k].idx, wr_q[k].data, exp_q[k].idx, exp_q[k].data);
                    end
                end
            end
            ridx = 16'($urandom);
            m = $urandom_range(1, 4);
            set_index(ridx, ok);
            bus_start();
            write_byte({DEV, I2C_RW_READ}, a);
            for (int k = 0; k < m; k++) begin
                read_byte(d, k != m - 1);
                p = 6'(ridx + 16'(k));
                n_tests++;
                if (d !== ref_mem[p]) begin
                    n_fail++; $display("FAIL rand_rd%0d_b%0d: got %0h want %0h", it, k, d, ref_mem[p]);
                end
            end
            bus_stop();
        end
    endtask

    task automatic test_abort();
        logic ok, a, b;
        logic [7:0] v;
        wr_q.delete();
        set_index(16'h0008, ok);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        bus_stop();
        n_tests++;
        if (wr_q.size() != 0 || busy !== 1'b0 || sda_oe !== 1'b0) begin
            n_fail++; $display("FAIL abort_stop: writes=%0d busy=%0b oe=%0b want 0/0/0", wr_q.size(), busy, sda_oe);
        end
        n_tests++;
        if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        peek(6'h08, v);
        n_tests++;
        if (v !== ref_mem[8]) begin n_fail++; $display("FAIL abort_mem: got %0h want %0h", v, ref_mem[8]); end

        set_index(16'h0020, ok);
        write_byte(8'h0F, a);
        bus_stop();
        ref_mem[6'h20] = 8'h0F;
        set_index(16'h0020, ok);
        bus_start();
        write_byte({DEV, I2C_RW_READ}, a);
        read_bit(b);
        n_tests++;
        if (b !== ref_mem[6'h20][7]) begin n_fail++; $display("FAIL rst_rd_bit7: got %0b want %0b", b, ref_mem[6'h20][7]); end
        read_bit(b);
        repeat (2) @(negedge clk);
        n_tests++;
        if (sda_oe !== ~ref_mem[6'h20][5]) begin n_fail++; $display("FAIL rst_rd_drive: oe=%0b want %0b", sda_oe, ~ref_mem[6'h20][5]); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_release: oe=%0b want 0", sda_oe); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_fail++; $display("FAIL rst_state: busy=%0b state=%0d want 0/%0d", busy, dut.state_q, ST_IDLE);
        end
        rst_n = 1'b1;
        wr_q.delete();
        read_bit(b); read_bit(b); read_bit(b);
        bus_stop();
        n_tests++;
        if (wr_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_ignore: writes=%0d busy=%0b want 0/0", wr_q.size(), busy);
        end
        peek(6'h20, v);
        n_tests++;
        if (v !== ref_mem[6'h20]) begin n_fail++; $display("FAIL rst_mem_clear: got %0h want %0h", v, ref_mem[6'h20]); end
        set_index(16'h0005, ok);
        write_byte(8'h99, a);
        bus_stop();
        ref_mem[5] = 8'h99;
        peek(6'h05, v);
        n_tests++;
        if ((ok & a) !== 1'b1 || v !== ref_mem[5]) begin
            n_fail++; $display("FAIL rst_recover: acks=%0b mem=%0h want 1/%0h", ok & a, v, ref_mem[5]);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_random_read();
        test_bad_addr();
        test_wrap();
        test_random();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
